// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register-write arbiter.
//   state_t         : arbiter FSM states (IDLE / WRITE / ACK)
//   GRANT_ACC/LD    : encoding of last_grant and the internal winner flag
//   DATA_W_DEFAULT  : default write-data width
//   pick_winner()   : round-robin choice between the two requesters
package reg_write_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam logic GRANT_ACC = 1'b0;
  localparam logic GRANT_LD  = 1'b1;

  localparam int DATA_W_DEFAULT = 16;

  // Returns GRANT_LD when the load path wins. On a tie the requester that
  // did not win last time is chosen, so neither path can starve the other.
  function automatic logic pick_winner(input logic acc_req,
                                       input logic ld_req,
                                       input logic last_grant);
    if (acc_req && ld_req) begin
      return (last_grant == GRANT_ACC) ? GRANT_LD : GRANT_ACC;
    end
    return ld_req ? GRANT_LD : GRANT_ACC;
  endfunction

endpackage

// File: rtl/reg_dest_decoder.sv
// Decodes a 2-bit register index into a one-hot strobe vector.
//   index  : target register index
//   en     : when low the whole vector is 0
//   onehot : bit <index> high when en is high
module reg_dest_decoder #(
  parameter int NUM_REGS = 4
) (
  input  logic [1:0]          index,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    // NOTE: assigning a default before any conditional write keeps this
    // block purely combinational; without it the tool infers a latch.
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (index == 2'(i))) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates between an accumulator-path write and a memory-load write into
// a small bank of target registers. A granted write is captured, presented
// for exactly one cycle as a one-hot strobe plus value, then acknowledged for
// exactly one cycle to the winner.
//   clk, reset                     : clock, asynchronous active-high reset
//   acc_req/acc_dest/acc_data      : accumulator write request (held until ack)
//   acc_ack                        : one-cycle completion pulse for acc
//   ld_req/ld_dest/ld_data         : load write request (held until ack)
//   ld_ack                         : one-cycle completion pulse for load
//   wr_acc_op, wr_acc_val          : acc strobe (one-hot) and value
//   wr_load,   wr_data_val         : load strobe (one-hot) and value
//   busy                           : FSM not in IDLE
//   last_grant                     : most recent winner (0 = acc, 1 = load)
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = DATA_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                acc_req,
  input  logic [1:0]          acc_dest,
  input  logic [DATA_W-1:0]   acc_data,
  output logic                acc_ack,
  input  logic                ld_req,
  input  logic [1:0]          ld_dest,
  input  logic [DATA_W-1:0]   ld_data,
  output logic                ld_ack,
  output logic [NUM_REGS-1:0] wr_acc_op,
  output logic [NUM_REGS-1:0] wr_load,
  output logic [DATA_W-1:0]   wr_acc_val,
  output logic [DATA_W-1:0]   wr_data_val,
  output logic                busy,
  output logic                last_grant
);

  state_t              state;
  logic                grant_any;
  logic                win_ld;
  logic [1:0]          win_dest;
  logic [DATA_W-1:0]   win_data;
  logic [NUM_REGS-1:0] acc_op_nxt;
  logic [NUM_REGS-1:0] load_nxt;

  // Requests only matter in IDLE; in WRITE/ACK the decoders are disabled and
  // the FSM does not look at the inputs, so late input changes are ignored.
  assign grant_any = (state == IDLE) && (acc_req || ld_req);
  assign win_ld    = pick_winner(acc_req, ld_req, last_grant);
  assign win_dest  = (win_ld == GRANT_LD) ? ld_dest : acc_dest;
  assign win_data  = (win_ld == GRANT_LD) ? ld_data : acc_data;

  reg_dest_decoder #(.NUM_REGS(NUM_REGS)) u_acc_dec (
    .index  (win_dest),
    .en     (grant_any && (win_ld == GRANT_ACC)),
    .onehot (acc_op_nxt)
  );

  reg_dest_decoder #(.NUM_REGS(NUM_REGS)) u_ld_dec (
    .index  (win_dest),
    .en     (grant_any && (win_ld == GRANT_LD)),
    .onehot (load_nxt)
  );

  assign busy = (state != IDLE);

  // The strobe and value registers double as the capture registers: they are
  // loaded with the winner's decoded dest and data at the grant edge and are
  // therefore valid for exactly the WRITE cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= GRANT_LD;  // acc wins the first tie after reset
      wr_acc_op   <= '0;
      wr_load     <= '0;
      wr_acc_val  <= '0;
      wr_data_val <= '0;
      acc_ack     <= 1'b0;
      ld_ack      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            state       <= WRITE;
            last_grant  <= win_ld;
            wr_acc_op   <= acc_op_nxt;
            wr_load     <= load_nxt;
            wr_acc_val  <= (win_ld == GRANT_ACC) ? win_data : '0;
            wr_data_val <= (win_ld == GRANT_LD)  ? win_data : '0;
          end
        end
        WRITE: begin
          state       <= ACK;
          wr_acc_op   <= '0;
          wr_load     <= '0;
          wr_acc_val  <= '0;
          wr_data_val <= '0;
          acc_ack     <= (last_grant == GRANT_ACC);
          ld_ack      <= (last_grant == GRANT_LD);
        end
        ACK: begin
          state   <= IDLE;
          acc_ack <= 1'b0;
          ld_ack  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 4, meaning the number of 16-bit target registers.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the data width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 acc_req  input  1  accumulator-path write request; held high until acc_ack.
REQ-006 acc_dest  input  2  target register index for the acc request.
REQ-007 acc_data  input  DATA_W  write value for the acc request.
REQ-008 acc_ack  output  1  one-cycle completion pulse for the acc request.
REQ-009 ld_req  input  1  memory-load write request; held high until ld_ack.
REQ-010 ld_dest  input  2  target register index for the load request.
REQ-011 ld_data  input  DATA_W  write value for the load request.
REQ-012 ld_ack  output  1  one-cycle completion pulse for the load request.
REQ-013 wr_acc_op  output  NUM_REGS  one-hot acc_op strobe, one bit per target register.
REQ-014 wr_load  output  NUM_REGS  one-hot load strobe, one bit per target register.
REQ-015 wr_acc_val  output  DATA_W  value presented on the registers' acc_val port.
REQ-016 wr_data_val  output  DATA_W  value presented on the registers' data_val port.
REQ-017 busy  output  1  high whenever the state is not IDLE.
REQ-018 last_grant  output  1  most recent winner: 0 = acc, 1 = load.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, WRITE and ACK.
REQ-020 IDLE, no request: the FSM SHALL stay in IDLE.
REQ-021 IDLE, exactly one request high: that requester SHALL be granted; next state WRITE.
REQ-022 IDLE, both requests high: the requester not equal to last_grant SHALL be granted (round-robin).
REQ-023 On grant, the winner's dest and data SHALL be captured into internal registers, and last_grant SHALL update to the winner.
REQ-024 Input changes after grant SHALL have no effect on the current write.
REQ-025 WRITE SHALL last exactly one cycle.
- Acc grant: bit dest of wr_acc_op high, and wr_acc_val = captured data.
- Load grant: bit dest of wr_load high, and wr_data_val = captured data.
- Next state: ACK.
REQ-026 ACK SHALL last exactly one cycle: the winner's ack is high, then the FSM returns to IDLE.
REQ-027 Requests SHALL be ignored while in WRITE or ACK.
REQ-028 A request still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-029 Latency: request sampled at edge N -> strobe during cycle N+1 -> ack during cycle N+2; maximum throughput is one write per 3 cycles.
REQ-030 Outside WRITE, all strobe bits SHALL be 0, and wr_acc_val and wr_data_val SHALL be 0.
REQ-031 At most one bit across wr_acc_op and wr_load together SHALL be high in any cycle.
REQ-032 acc_ack and ld_ack SHALL never be high in the same cycle.
REQ-033 Both requesters targeting the same dest SHALL be serialized in round-robin order; the second write lands last.
REQ-034 A request dropped before it is granted SHALL produce no write and no ack.

Reset
REQ-035 While reset is high, the block SHALL hold the following values: state IDLE, all strobes 0, both data outputs 0, both acks 0, busy 0, last_grant 1, so acc wins the first tie.
REQ-036 Reset asserted during WRITE or ACK SHALL abort the operation: no ack is issued, and the requester must re-request.

Structure
REQ-037 A shared package SHALL hold the state enumeration (IDLE/WRITE/ACK), the GRANT_ACC=0 and GRANT_LD=1 constants, and the DATA_W default.
REQ-038 The one-hot index decode SHALL be the sub-module reg_dest_decoder (2-bit index + enable -> NUM_REGS one-hot), instantiated once per strobe vector.

Verification
REQ-039 Single acc: acc_req=1, acc_dest=2, acc_data=16'h1234 -> next cycle wr_acc_op=4'b0100 with wr_acc_val=16'h1234, then acc_ack for 1 cycle.
REQ-040 Single load: ld_req=1, ld_dest=0, ld_data=16'hBEEF -> wr_load=4'b0001 with wr_data_val=16'hBEEF, then ld_ack; wr_acc_op stays 0.
REQ-041 Tie after reset: both requests on dest 1, acc_data=16'h0001, ld_data=16'h0002 -> acc written first (wr_acc_op=4'b0010), then load written (wr_load=4'b0010); last_grant ends at 1.
REQ-042 Fairness: both requests held continuously for 12 cycles -> grants alternate acc, ld, acc, ld at a 3-cycle period.
REQ-043 Reset mid-op: assert reset during the WRITE cycle of a load request -> all outputs 0 immediately, no ld_ack, busy=0.
REQ-044 Data change after grant: change acc_data from 16'hAAAA to 16'h5555 in the WRITE cycle -> wr_acc_val=16'hAAAA.
